// File: rtl/lift_pkg.sv
// lift_pkg -- shared definitions for the hall-call encoder.
//   * call codes presented to the lift controller, indexed by btn bit
//   * lift direction codes as reported by the lift controller
//   * encoder FSM state encoding
package lift_pkg;

  localparam int NUM_CALLS = 6;

  // Call codes, in btn bit order.
  localparam logic [2:0] CODE_1U = 3'b001;
  localparam logic [2:0] CODE_2U = 3'b010;
  localparam logic [2:0] CODE_3U = 3'b011;
  localparam logic [2:0] CODE_2D = 3'b110;
  localparam logic [2:0] CODE_3D = 3'b111;
  localparam logic [2:0] CODE_4D = 3'b100;

  // Direction codes; 2'b11 is not named and behaves like STAY.
  typedef enum logic [1:0] {
    DIR_UP   = 2'b00,
    DIR_DOWN = 2'b01,
    DIR_STAY = 2'b10
  } dir_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_PRESENT = 2'b01,
    ST_MOVING  = 2'b10,
    ST_DONE    = 2'b11
  } enc_state_e;

  // Map a pending-bit index to the code driven on req_code.
  function automatic logic [2:0] call_code(input logic [2:0] idx);
    logic [2:0] code;
    case (idx)
      3'd0:    code = CODE_1U;
      3'd1:    code = CODE_2U;
      3'd2:    code = CODE_3U;
      3'd3:    code = CODE_2D;
      3'd4:    code = CODE_3D;
      3'd5:    code = CODE_4D;
      default: code = CODE_1U;
    endcase
    return code;
  endfunction

  // Only UP and DOWN count as lift motion; STAY and 2'b11 do not.
  function automatic logic dir_is_motion(input logic [1:0] dir);
    return (dir == DIR_UP) || (dir == DIR_DOWN);
  endfunction

endpackage

// File: rtl/lift_call_encoder_if.sv
// lift_call_encoder_if -- hall-call side and lift-controller side signals.
//   btn       : hall-call button pulses (bit order _1U,_2U,_3U,_2D,_3D,_4D)
//   lift_dir  : direction reported by the lift controller
//   req_code  : call code presented to the lift controller
//   req_valid : high while a call is presented or being served
//   pending   : latched outstanding calls, btn bit order
// master drives btn/lift_dir (environment), slave is the encoder.
interface lift_call_encoder_if;
  logic [5:0] btn;
  logic [1:0] lift_dir;
  logic [2:0] req_code;
  logic       req_valid;
  logic [5:0] pending;

  modport master (
    output btn,
    output lift_dir,
    input  req_code,
    input  req_valid,
    input  pending
  );

  modport slave (
    input  btn,
    input  lift_dir,
    output req_code,
    output req_valid,
    output pending
  );
endinterface

// File: rtl/rr_arbiter6.sv
// rr_arbiter6 -- combinational 6-way round-robin picker.
//   req         : request vector
//   ptr         : index searched first (0..5)
//   grant_idx   : first requesting index at or after ptr, wrapping 5 -> 0
//   grant_valid : any request present
module rr_arbiter6 (
  input  logic [5:0] req,
  input  logic [2:0] ptr,
  output logic [2:0] grant_idx,
  output logic       grant_valid
);

  logic [2:0] cand_idx [6];
  logic [5:0] cand_hit;

  // Candidate gi is the index visited gi steps after ptr.
  generate
    for (genvar gi = 0; gi < 6; gi++) begin : g_cand
      logic [3:0] sum;
      assign sum           = {1'b0, ptr} + 4'(gi);
      assign cand_idx[gi]  = (sum >= 4'd6) ? 3'(sum - 4'd6) : sum[2:0];
      assign cand_hit[gi]  = req[cand_idx[gi]];
    end
  endgenerate

  // Walk from the farthest candidate back so the nearest hit wins.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = 3'd0;
    for (int k = 5; k >= 0; k--) begin
      if (cand_hit[k]) begin
        grant_valid = 1'b1;
        grant_idx   = cand_idx[k];
      end
    end
  end

endmodule

// File: rtl/lift_call_encoder.sv
// lift_call_encoder -- latches hall-call button presses and presents them
// one at a time, round-robin, to the lift controller request input.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : slave side of lift_call_encoder_if (btn, lift_dir in;
//          req_code, req_valid, pending out)
// A presented call is served either by lift motion followed by two
// consecutive non-motion cycles, or in place after TIMEOUT cycles of
// presentation without motion.
module lift_call_encoder
  import lift_pkg::*;
#(
  parameter int MIN_HOLD = 4,
  parameter int TIMEOUT  = 32
) (
  input logic              clk,
  input logic              rst,
  lift_call_encoder_if.slave bus
);

  localparam int              CNT_W    = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] HOLD_MIN = CNT_W'(MIN_HOLD);

  enc_state_e       state_reg, state_next;
  logic [5:0]       pending_reg, pending_next;
  logic [2:0]       ptr_reg, ptr_next;
  logic [2:0]       sel_reg, sel_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [2:0]       code_reg, code_next;
  logic             stay_reg, stay_next;
  logic             valid_reg, valid_next;

  logic       motion;
  logic [2:0] grant_idx;
  logic       grant_valid;

  assign motion = dir_is_motion(bus.lift_dir);

  rr_arbiter6 u_arb (
    .req         (pending_reg),
    .ptr         (ptr_reg),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (grant_valid) state_next = ST_PRESENT;
      end
      ST_PRESENT: begin
        // Motion is only accepted once the code has been held long enough;
        // motion takes priority over the in-place timeout.
        if ((cnt_reg >= HOLD_MIN) && motion) begin
          state_next = ST_MOVING;
        end else if ((cnt_reg == CNT_MAX) && !motion) begin
          state_next = ST_DONE;
        end
      end
      ST_MOVING: begin
        // stay_reg remembers that the previous MOVING cycle was non-motion.
        if (!motion && stay_reg) state_next = ST_DONE;
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Register-input logic for the datapath.
  always_comb begin
    pending_next = pending_reg | bus.btn;
    ptr_next     = ptr_reg;
    sel_next     = sel_reg;
    cnt_next     = cnt_reg;
    code_next    = code_reg;
    stay_next    = 1'b0;
    valid_next   = (state_next == ST_PRESENT) || (state_next == ST_MOVING);

    case (state_reg)
      ST_IDLE: begin
        cnt_next = '0;
        if (grant_valid) begin
          sel_next  = grant_idx;
          code_next = call_code(grant_idx);
        end
      end
      ST_PRESENT: begin
        if (cnt_reg != CNT_MAX) cnt_next = cnt_reg + 1'b1;
      end
      ST_MOVING: begin
        stay_next = !motion;
      end
      ST_DONE: begin
        // A press landing in this same cycle re-sets the bit being cleared.
        pending_next = (pending_reg & ~(6'd1 << sel_reg)) | bus.btn;
        ptr_next     = (sel_reg == 3'd5) ? 3'd0 : 3'(sel_reg + 3'd1);
      end
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_reg <= '0;
      ptr_reg     <= 3'd0;
      sel_reg     <= 3'd0;
      cnt_reg     <= '0;
      code_reg    <= CODE_1U;
      stay_reg    <= 1'b0;
      valid_reg   <= 1'b0;
    end else begin
      pending_reg <= pending_next;
      ptr_reg     <= ptr_next;
      sel_reg     <= sel_next;
      cnt_reg     <= cnt_next;
      code_reg    <= code_next;
      stay_reg    <= stay_next;
      valid_reg   <= valid_next;
    end
  end

  assign bus.req_code  = code_reg;
  assign bus.req_valid = valid_reg;
  assign bus.pending   = pending_reg;

endmodule
